// File: rtl/serial_accum_bank_if.sv
// Command/serial-stream bundle for serial_accum_bank.
// master: drives bit timing, commands, operand stream and ovf_clr.
// slave : returns cmd_ready, acc_out, busy, done and the sticky ovf flag.
// ACC_W must equal the bank's max(1, $clog2(NUM_ACC)).
interface serial_accum_bank_if #(
    parameter int unsigned ACC_W = 1
);
    logic             bit_en;       // bit-time strobe
    logic             frame_start;  // with bit_en: operand bit 0
    logic             cmd_valid;
    logic [1:0]       cmd_op;       // 0=CLEAR 1=LOAD 2=ADD 3=SUB
    logic [ACC_W-1:0] cmd_sel;
    logic             cmd_ready;
    logic             op_in;        // serial operand, LSB first
    logic             acc_out;      // serial pre-op value of selected acc
    logic             busy;
    logic             done;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output bit_en, frame_start, cmd_valid, cmd_op, cmd_sel, op_in, ovf_clr,
        input  cmd_ready, acc_out, busy, done, ovf
    );

    modport slave (
        input  bit_en, frame_start, cmd_valid, cmd_op, cmd_sel, op_in, ovf_clr,
        output cmd_ready, acc_out, busy, done, ovf
    );
endinterface

// File: rtl/serial_accum_bank.sv
// Bit-serial accumulator bank. NUM_ACC two's-complement accumulators of
// WORD_BITS*PREC_WORDS bits each. One command (CLEAR/LOAD/ADD/SUB) at a time runs
// against one accumulator over a full serial frame, LSB first, one bit per bit_en.
// Ports:
//   CLOCK : system clock, rising edge
//   rst   : synchronous reset, active low
//   bus   : serial_accum_bank_if.slave (command handshake, serial data, status)
module serial_accum_bank #(
    parameter int unsigned WORD_BITS  = 29,
    parameter int unsigned PREC_WORDS = 1,
    parameter int unsigned NUM_ACC    = 1
) (
    input logic                CLOCK,
    input logic                rst,
    serial_accum_bank_if.slave bus
);
    localparam int unsigned FRAME_BITS = WORD_BITS * PREC_WORDS;
    localparam int unsigned ACC_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int unsigned CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [1:0] OpClear = 2'd0;
    localparam logic [1:0] OpLoad  = 2'd1;
    localparam logic [1:0] OpAdd   = 2'd2;
    localparam logic [1:0] OpSub   = 2'd3;

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q;
    logic [ACC_W-1:0]      sel_q;
    logic                  carry_q, carry_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [FRAME_BITS-1:0] acc_q [NUM_ACC];

    logic accept, proc, first, last;
    logic a_bit, b_bit, c_in, c_out, sum_bit, res_bit, ovf_set;

    assign accept = (state_q == StIdle) && bus.cmd_valid;
    assign last   = (cnt_q == CNT_W'(FRAME_BITS - 1));

    // LSB of the selected accumulator; an out-of-range select reads as 0.
    always_comb begin
        a_bit = 1'b0;
        for (int i = 0; i < int'(NUM_ACC); i++) begin
            if (sel_q == ACC_W'(i)) a_bit = acc_q[i][0];
        end
    end

    always_comb begin
        state_d = state_q;
        proc    = 1'b0;
        first   = 1'b0;
        case (state_q)
            StIdle:  if (bus.cmd_valid) state_d = StArmed;
            StArmed: begin
                // The aligning strobe is itself operand bit 0.
                if (bus.bit_en && bus.frame_start) begin
                    proc    = 1'b1;
                    first   = 1'b1;
                    state_d = last ? StDone : StRun;
                end
            end
            StRun: begin
                if (bus.bit_en) begin
                    proc = 1'b1;
                    if (last) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Serial ALU: SUB is a + ~b + 1, the +1 being the initial carry.
    always_comb begin
        b_bit   = (op_q == OpSub) ? ~bus.op_in : bus.op_in;
        c_in    = first ? (op_q == OpSub) : carry_q;
        sum_bit = a_bit ^ b_bit ^ c_in;
        c_out   = (a_bit & b_bit) | (a_bit & c_in) | (b_bit & c_in);
        case (op_q)
            OpClear: res_bit = 1'b0;
            OpLoad:  res_bit = bus.op_in;
            default: res_bit = sum_bit;
        endcase
        ovf_set = proc && last && ((op_q == OpAdd) || (op_q == OpSub)) && (c_in ^ c_out);
        carry_d = proc ? c_out : carry_q;
        cnt_d   = proc ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        // Set wins over a simultaneous clear.
        ovf_d   = ovf_set | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OpClear;
            sel_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_ACC); i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (accept) begin
                op_q  <= bus.cmd_op;
                sel_q <= bus.cmd_sel;
            end
            for (int i = 0; i < int'(NUM_ACC); i++) begin
                if (proc && (sel_q == ACC_W'(i))) begin
                    acc_q[i] <= {res_bit, acc_q[i][FRAME_BITS-1:1]};
                end
            end
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.ovf       = ovf_q;
    // Streams the old value for every processed bit, including bit 0 taken in ARMED.
    assign bus.acc_out   = ((state_q == StRun) || first) ? a_bit : 1'b0;
endmodule

// File: tb/tb_serial_accum_bank.sv
module tb_serial_accum_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0, frame_start = 1'b0, op_in = 1'b0, ovf_clr = 1'b0;
    logic       cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
    logic [1:0] cmd_op = 2'd0, cmd_sel = 2'd0;
    logic       use_b = 1'b0;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    // A: single precision, four accumulators. B: double precision, one accumulator.
    serial_accum_bank_if #(.ACC_W(2)) if_a ();
    serial_accum_bank_if #(.ACC_W(1)) if_b ();

    assign if_a.bit_en = bit_en;  assign if_a.frame_start = frame_start;
    assign if_a.cmd_valid = cmd_valid_a;  assign if_a.cmd_op = cmd_op;
    assign if_a.cmd_sel = cmd_sel;  assign if_a.op_in = op_in;  assign if_a.ovf_clr = ovf_clr;
    assign if_b.bit_en = bit_en;  assign if_b.frame_start = frame_start;
    assign if_b.cmd_valid = cmd_valid_b;  assign if_b.cmd_op = cmd_op;
    assign if_b.cmd_sel = cmd_sel[0];  assign if_b.op_in = op_in;  assign if_b.ovf_clr = ovf_clr;

    serial_accum_bank #(.WORD_BITS(29), .PREC_WORDS(1), .NUM_ACC(4)) dut_a (
        .CLOCK(clk), .rst(rst_n), .bus(if_a)
    );
    serial_accum_bank #(.WORD_BITS(29), .PREC_WORDS(2), .NUM_ACC(1)) dut_b (
        .CLOCK(clk), .rst(rst_n), .bus(if_b)
    );

    wire s_ready = use_b ? if_b.cmd_ready : if_a.cmd_ready;
    wire s_busy  = use_b ? if_b.busy      : if_a.busy;
    wire s_done  = use_b ? if_b.done      : if_a.done;
    wire s_acc   = use_b ? if_b.acc_out   : if_a.acc_out;
    wire s_ovf   = use_b ? if_b.ovf       : if_a.ovf;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command and stream a full frame. Frame_start/bit_en are also raised
    // in the accept cycle as noise that must be ignored.
    task automatic run_op(input bit which, input logic [1:0] op, input logic [1:0] sel,
                          input logic [57:0] operand, input int nbits, input int gap_pct,
                          input bit fs_mid, input bit clr_last, output logic [57:0] cap,
                          output int done_cnt, output bit done_ok, output bit armed_ok,
                          output bit accept_ok);
        int w;
        cap = '0; done_cnt = 0; done_ok = 1'b0; armed_ok = 1'b0; w = 0;
        use_b = which; cmd_op = op; cmd_sel = sel;
        cmd_valid_a = !which; cmd_valid_b = which;
        bit_en = 1'b1; frame_start = 1'b1; op_in = 1'b1;
        @(negedge clk);
        while (!s_ready && w < 20) begin
            @(posedge clk); #1; @(negedge clk); w++;
        end
        accept_ok = s_ready;
        @(posedge clk); #1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; bit_en = 1'b0; frame_start = 1'b0; op_in = 1'b0;
        @(negedge clk);
        armed_ok = s_busy && !s_ready && !s_done;
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                bit_en = 1'b0; frame_start = 1'b0; op_in = ~op_in;
                @(negedge clk); if (s_done) done_cnt++;
                @(posedge clk); #1;
            end
            bit_en = 1'b1; frame_start = (i == 0) || (fs_mid && i == 3);
            op_in = operand[i]; ovf_clr = clr_last && (i == nbits - 1);
            @(negedge clk); cap[i] = s_acc; if (s_done) done_cnt++;
            @(posedge clk); #1;
        end
        bit_en = 1'b0; frame_start = 1'b0; ovf_clr = 1'b0; op_in = 1'b0;
        @(negedge clk); done_ok = s_done; if (s_done) done_cnt++;
        repeat (3) begin
            @(posedge clk); #1; @(negedge clk); if (s_done) done_cnt++;
        end
        @(posedge clk); #1;
    endtask

    // Read by ADD 0: streams the old value and leaves it unchanged.
    task automatic read_acc(input bit which, input logic [1:0] sel, input int nbits,
                            output logic [57:0] val);
        int dc; bit d, ar, ac;
        run_op(which, 2'd2, sel, 58'd0, nbits, 0, 1'b0, 1'b0, val, dc, d, ar, ac);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", if_a.cmd_ready); end
        if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
        if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
        if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", if_a.ovf); end
        if (if_a.acc_out !== 1'b0) begin n_fail++; $display("FAIL reset_acc_out: got %b want 0", if_a.acc_out); end
        if (if_b.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %b want 1", if_b.cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_add();
        logic [57:0] cap; int dc; bit d, ar, ac;
        run_op(1'b0, 2'd1, 2'd0, 58'd5, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks += 4;
        if (ac !== 1'b1) begin n_fail++; $display("FAIL load_accept: got %b want 1", ac); end
        if (ar !== 1'b1) begin n_fail++; $display("FAIL armed_busy_not_ready: got %b want 1", ar); end
        if (d !== 1'b1) begin n_fail++; $display("FAIL load_done_timing: got %b want 1", d); end
        if (dc != 1) begin n_fail++; $display("FAIL load_done_count: got %0d want 1", dc); end
        // frame_start on bit 3 must not re-align the frame
        run_op(1'b0, 2'd2, 2'd0, 58'd7, 29, 0, 1'b1, 1'b0, cap, dc, d, ar, ac);
        n_checks += 3;
        if (cap[28:0] !== 29'd5) begin n_fail++; $display("FAIL add_acc_out_stream: got %h want 5", cap[28:0]); end
        if (dc != 1 || d !== 1'b1) begin n_fail++; $display("FAIL add_done: got cnt %0d first %b want 1 1", dc, d); end
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b want 0", s_ovf); end
        read_acc(1'b0, 2'd0, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'h000000C) begin n_fail++; $display("FAIL add_result: got %h want 000000c", cap[28:0]); end
    endtask

    task automatic test_sub();
        logic [57:0] cap; int dc; bit d, ar, ac;
        run_op(1'b0, 2'd3, 2'd0, 58'd20, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks += 2;
        if (cap[28:0] !== 29'd12) begin n_fail++; $display("FAIL sub_acc_out_stream: got %h want c", cap[28:0]); end
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b want 0", s_ovf); end
        read_acc(1'b0, 2'd0, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'h1FFFFFF8) begin n_fail++; $display("FAIL sub_result: got %h want 1ffffff8", cap[28:0]); end
    endtask

    task automatic test_ovf();
        logic [57:0] cap; int dc; bit d, ar, ac;
        run_op(1'b0, 2'd1, 2'd0, 58'h0FFFFFFF, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        run_op(1'b0, 2'd2, 2'd0, 58'd1, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks++;
        if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", s_ovf); end
        read_acc(1'b0, 2'd0, 29, cap);
        n_checks += 2;
        if (cap[28:0] !== 29'h10000000) begin n_fail++; $display("FAIL ovf_result: got %h want 10000000", cap[28:0]); end
        if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", s_ovf); end
        ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0; @(negedge clk);
        n_checks++;
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_first: got %b want 0", s_ovf); end
        @(posedge clk); #1;
        run_op(1'b0, 2'd1, 2'd0, 58'h0FFFFFFF, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        run_op(1'b0, 2'd2, 2'd0, 58'd1, 29, 0, 1'b0, 1'b1, cap, dc, d, ar, ac);
        n_checks++;
        if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b want 1", s_ovf); end
        ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0; @(negedge clk);
        n_checks++;
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_alone: got %b want 0", s_ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_multi_acc();
        logic [57:0] cap; int dc; bit d, ar, ac;
        // CLEAR ignores op_in: stream all ones
        run_op(1'b0, 2'd0, 2'd0, {58{1'b1}}, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks++;
        if (dc != 1 || d !== 1'b1) begin n_fail++; $display("FAIL clear_done: got cnt %0d first %b want 1 1", dc, d); end
        run_op(1'b0, 2'd1, 2'd2, 58'd9, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        run_op(1'b0, 2'd2, 2'd1, 58'd3, 29, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        read_acc(1'b0, 2'd0, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd0) begin n_fail++; $display("FAIL multi_acc0: got %h want 0", cap[28:0]); end
        read_acc(1'b0, 2'd1, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd3) begin n_fail++; $display("FAIL multi_acc1: got %h want 3", cap[28:0]); end
        read_acc(1'b0, 2'd2, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd9) begin n_fail++; $display("FAIL multi_acc2: got %h want 9", cap[28:0]); end
        read_acc(1'b0, 2'd3, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd0) begin n_fail++; $display("FAIL multi_acc3: got %h want 0", cap[28:0]); end
    endtask

    task automatic test_double();
        logic [57:0] cap; int dc; bit d, ar, ac;
        run_op(1'b1, 2'd1, 2'd0, 58'h1FFFFFFF, 58, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        run_op(1'b1, 2'd2, 2'd0, 58'd1, 58, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks += 2;
        if (dc != 1 || d !== 1'b1) begin n_fail++; $display("FAIL dbl_done: got cnt %0d first %b want 1 1", dc, d); end
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL dbl_ovf: got %b want 0", s_ovf); end
        read_acc(1'b1, 2'd0, 58, cap);
        n_checks++;
        if (cap !== 58'h20000000) begin n_fail++; $display("FAIL dbl_result: got %h want 20000000", cap); end
        run_op(1'b1, 2'd1, 2'd0, 58'h1FFFFFFF, 58, 70, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks++;
        if (cap !== 58'h20000000) begin n_fail++; $display("FAIL dbl_gap_stream: got %h want 20000000", cap); end
        run_op(1'b1, 2'd2, 2'd0, 58'd1, 58, 70, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks += 2;
        if (dc != 1 || d !== 1'b1) begin n_fail++; $display("FAIL dbl_gap_done: got cnt %0d first %b want 1 1", dc, d); end
        if (cap !== 58'h1FFFFFFF) begin n_fail++; $display("FAIL dbl_gap_old: got %h want 1fffffff", cap); end
        read_acc(1'b1, 2'd0, 58, cap);
        n_checks++;
        if (cap !== 58'h20000000) begin n_fail++; $display("FAIL dbl_gap_result: got %h want 20000000", cap); end
    endtask

    task automatic test_bad_sel();
        logic [57:0] cap; int dc; bit d, ar, ac;
        run_op(1'b1, 2'd1, 2'd1, 58'h123, 58, 0, 1'b0, 1'b0, cap, dc, d, ar, ac);
        n_checks += 2;
        if (dc != 1 || d !== 1'b1) begin n_fail++; $display("FAIL badsel_done: got cnt %0d first %b want 1 1", dc, d); end
        if (cap !== 58'd0) begin n_fail++; $display("FAIL badsel_acc_out: got %h want 0", cap); end
        read_acc(1'b1, 2'd0, 58, cap);
        n_checks++;
        if (cap !== 58'h20000000) begin n_fail++; $display("FAIL badsel_acc0: got %h want 20000000", cap); end
    endtask

    task automatic test_reset_mid();
        logic [57:0] cap; int dc;
        dc = 0;
        use_b = 1'b0; cmd_op = 2'd1; cmd_sel = 2'd2; cmd_valid_a = 1'b1;
        @(posedge clk); #1 cmd_valid_a = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            bit_en = 1'b1; frame_start = (i == 0); op_in = 1'b1;
            if (i == 10) rst_n = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1; bit_en = 1'b0; frame_start = 1'b0; op_in = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (if_a.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", if_a.cmd_ready); end
        if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", if_a.busy); end
        if (if_a.done) dc++;
        repeat (3) begin @(posedge clk); #1; @(negedge clk); if (if_a.done) dc++; end
        n_checks++;
        if (dc != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dc); end
        @(posedge clk); #1;
        read_acc(1'b0, 2'd2, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd0) begin n_fail++; $display("FAIL rstmid_acc2: got %h want 0", cap[28:0]); end
        read_acc(1'b0, 2'd1, 29, cap);
        n_checks++;
        if (cap[28:0] !== 29'd0) begin n_fail++; $display("FAIL rstmid_acc1: got %h want 0", cap[28:0]); end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_sub();
        test_ovf();
        test_multi_acc();
        test_double();
        test_bad_sel();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
